// File: rtl/vga_fb_pkg.sv
// Shared constants, host FSM states and pixel-address helpers for the
// 1-bpp 640x480 framebuffer.
package vga_fb_pkg;

    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int WORD_W         = 16;
    localparam int WORDS_PER_LINE = H_ACTIVE / WORD_W;
    localparam int DEPTH          = WORDS_PER_LINE * V_ACTIVE;
    localparam int AW             = 15;
    localparam int BW             = $clog2(WORD_W);
    localparam int XW             = 10;
    localparam int YW             = 9;

    typedef enum logic [2:0] {IDLE, RD, MOD, WR, CLR} host_state_t;

    // Word address plus bit position inside that word
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [BW-1:0] bit_idx;
    } fb_loc_t;

    // Latched host pixel write
    typedef struct packed {
        fb_loc_t loc;
        logic    data;
    } wr_req_t;

    // y*40 is built from two shifts (32+8) so no multiplier is inferred
    function automatic fb_loc_t fb_loc(input logic [XW-1:0] x, input logic [YW-1:0] y);
        logic [AW-1:0] y_w;
        logic [AW-1:0] x_w;
        fb_loc_t       loc;
        y_w         = AW'(y);
        x_w         = AW'(x[XW-1:BW]);
        loc.addr    = (y_w << 5) + (y_w << 3) + x_w;
        loc.bit_idx = x[BW-1:0];
        return loc;
    endfunction

    function automatic logic fb_in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
    endfunction

endpackage

// File: rtl/fb_ram_dp.sv
// Simple dual-port RAM: port A read-only, port B read/write, both with a
// registered read output. Read-first: a read of a word written on the same
// edge returns the old contents.
module fb_ram_dp
    import vga_fb_pkg::*;
#(
    parameter int RAM_W = WORD_W,
    parameter int RAM_D = DEPTH,
    parameter int RAM_A = AW
) (
    input  logic             Clk,
    input  logic             a_en,
    input  logic [RAM_A-1:0] a_addr,
    output logic [RAM_W-1:0] a_rdata,
    input  logic             b_en,
    input  logic             b_we,
    input  logic [RAM_A-1:0] b_addr,
    input  logic [RAM_W-1:0] b_wdata,
    output logic [RAM_W-1:0] b_rdata
);

    logic [RAM_W-1:0] mem [RAM_D];

    // Both ports in one block so the read-first ordering is explicit
    always_ff @(posedge Clk) begin
        if (a_en)
            a_rdata <= mem[a_addr];
        if (b_en) begin
            b_rdata <= mem[b_addr];
            if (b_we)
                mem[b_addr] <= b_wdata;
        end
    end

endmodule

// File: rtl/vga_fb_pixel_source.sv
// 1-bpp framebuffer pixel source: fixed 2-cycle display lookup on port A,
// host single-pixel read-modify-write and full-buffer clear on port B.
module vga_fb_pixel_source
    import vga_fb_pkg::*;
(
    input  logic          Clk,
    input  logic          Rst,
    input  logic          PixValid,
    input  logic [XW-1:0] PixX,
    input  logic [YW-1:0] PixY,
    output logic          Pixel,
    output logic          PixelValid,
    input  logic          WrValid,
    output logic          WrReady,
    input  logic [XW-1:0] WrX,
    input  logic [YW-1:0] WrY,
    input  logic          WrData,
    input  logic          ClrStart,
    input  logic          ClrColor,
    output logic          Busy,
    output logic          WrErr
);

    localparam int PIX_STAGES = 2;

    // ---------------- display path ----------------
    fb_loc_t                pix_loc;
    logic                   pix_ok;
    logic                   a_en;
    logic [WORD_W-1:0]      a_rdata;
    logic [PIX_STAGES:1]    vld_pipe;
    logic [BW-1:0]          bit_s1;
    logic                   ok_s1;

    assign pix_loc = fb_loc(PixX, PixY);
    assign pix_ok  = fb_in_range(PixX, PixY);
    // Out-of-range lookups never touch the RAM; they just produce a 0
    assign a_en    = PixValid & pix_ok;

    // Display pipeline: bit index travels alongside the RAM read, then select
    always_ff @(posedge Clk) begin
        if (Rst) begin
            vld_pipe <= '0;
            bit_s1   <= '0;
            ok_s1    <= 1'b0;
            Pixel    <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1], PixValid};
            bit_s1   <= pix_loc.bit_idx;
            ok_s1    <= a_en;
            Pixel    <= ok_s1 & a_rdata[bit_s1];
        end
    end

    assign PixelValid = vld_pipe[PIX_STAGES];

    // ---------------- host path ----------------
    host_state_t        state;
    wr_req_t            req;
    logic [WORD_W-1:0]  mod_word;
    logic [AW-1:0]      clr_cnt;
    logic               clr_color;
    fb_loc_t            wr_loc;
    logic               wr_ok;
    logic               b_en;
    logic               b_we;
    logic [AW-1:0]      b_addr;
    logic [WORD_W-1:0]  b_wdata;
    logic [WORD_W-1:0]  b_rdata;

    assign wr_loc = fb_loc(WrX, WrY);
    assign wr_ok  = fb_in_range(WrX, WrY);

    // Host FSM: clear has priority; bad coordinates are acked and flagged
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= IDLE;
            WrReady   <= 1'b0;
            Busy      <= 1'b0;
            WrErr     <= 1'b0;
            clr_cnt   <= '0;
            clr_color <= 1'b0;
            req       <= '0;
            mod_word  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    WrReady <= 1'b1;
                    if (WrReady) begin
                        if (ClrStart) begin
                            clr_color <= ClrColor;
                            clr_cnt   <= '0;
                            state     <= CLR;
                            WrReady   <= 1'b0;
                            Busy      <= 1'b1;
                        end else if (WrValid) begin
                            if (wr_ok) begin
                                req.loc  <= wr_loc;
                                req.data <= WrData;
                                state    <= RD;
                                WrReady  <= 1'b0;
                                Busy     <= 1'b1;
                            end else begin
                                WrErr <= 1'b1;
                            end
                        end
                    end
                end
                RD: state <= MOD;
                MOD: begin
                    mod_word                   <= b_rdata;
                    mod_word[req.loc.bit_idx]  <= req.data;
                    state                      <= WR;
                end
                WR: begin
                    state   <= IDLE;
                    WrReady <= 1'b1;
                    Busy    <= 1'b0;
                end
                CLR: begin
                    clr_cnt <= clr_cnt + AW'(1);
                    if (clr_cnt == AW'(DEPTH - 1)) begin
                        state   <= IDLE;
                        WrReady <= 1'b1;
                        Busy    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port B drive; Rst blocks the access so an aborted op writes nothing more
    always_comb begin
        b_en    = 1'b0;
        b_we    = 1'b0;
        b_addr  = req.loc.addr;
        b_wdata = mod_word;
        if (!Rst) begin
            case (state)
                RD: b_en = 1'b1;
                WR: begin
                    b_en = 1'b1;
                    b_we = 1'b1;
                end
                CLR: begin
                    b_en    = 1'b1;
                    b_we    = 1'b1;
                    b_addr  = clr_cnt;
                    b_wdata = {WORD_W{clr_color}};
                end
                default: ;
            endcase
        end
    end

    fb_ram_dp u_ram (
        .Clk     (Clk),
        .a_en    (a_en),
        .a_addr  (pix_loc.addr),
        .a_rdata (a_rdata),
        .b_en    (b_en),
        .b_we    (b_we),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_rdata (b_rdata)
    );

endmodule

// File: tb/tb_vga_fb_pixel_source.sv
// Directed bench for vga_fb_pixel_source: table-driven pixel reads plus
// hand-written clear/RMW/collision/reset sequences.
module tb_vga_fb_pixel_source;

    logic       Clk;
    logic       Rst;
    logic       PixValid;
    logic [9:0] PixX;
    logic [8:0] PixY;
    logic       Pixel;
    logic       PixelValid;
    logic       WrValid;
    logic       WrReady;
    logic [9:0] WrX;
    logic [8:0] WrY;
    logic       WrData;
    logic       ClrStart;
    logic       ClrColor;
    logic       Busy;
    logic       WrErr;

    vga_fb_pixel_source dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .PixValid   (PixValid),
        .PixX       (PixX),
        .PixY       (PixY),
        .Pixel      (Pixel),
        .PixelValid (PixelValid),
        .WrValid    (WrValid),
        .WrReady    (WrReady),
        .WrX        (WrX),
        .WrY        (WrY),
        .WrData     (WrData),
        .ClrStart   (ClrStart),
        .ClrColor   (ClrColor),
        .Busy       (Busy),
        .WrErr      (WrErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        int   phase;
        int   x;
        int   y;
        logic exp_pix;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add_vec(input int ph, input int x, input int y, input logic e);
        vec_t v;
        v.phase   = ph;
        v.x       = x;
        v.y       = y;
        v.exp_pix = e;
        vecs.push_back(v);
    endtask

    task automatic read_px(input int x, input int y, output logic pix, output logic vld);
        PixValid = 1'b1;
        PixX     = 10'(x);
        PixY     = 9'(y);
        tick();
        PixValid = 1'b0;
        tick();
        pix = Pixel;
        vld = PixelValid;
    endtask

    task automatic run_phase(input int ph);
        logic pix, vld;
        foreach (vecs[i]) begin
            if (vecs[i].phase == ph) begin
                read_px(vecs[i].x, vecs[i].y, pix, vld);
                check($sformatf("p%0d_pix(%0d,%0d)", ph, vecs[i].x, vecs[i].y), 32'(pix), 32'(vecs[i].exp_pix));
                check($sformatf("p%0d_vld(%0d,%0d)", ph, vecs[i].x, vecs[i].y), 32'(vld), 32'd1);
            end
        end
    endtask

    task automatic wait_ready(input string name);
        int i;
        i = 0;
        while (!WrReady && i < 100) begin
            tick();
            i++;
        end
        if (!WrReady)
            check({name, "_ready_timeout"}, 32'(WrReady), 32'd1);
    endtask

    task automatic host_write(input int x, input int y, input logic d, output int low);
        wait_ready("write");
        WrValid = 1'b1;
        WrX     = 10'(x);
        WrY     = 9'(y);
        WrData  = d;
        tick();
        WrValid = 1'b0;
        low = 0;
        while (!WrReady && low < 50) begin
            low++;
            tick();
        end
    endtask

    task automatic do_clear(input logic c, input logic with_wr, output int busy_cyc);
        wait_ready("clear");
        ClrStart = 1'b1;
        ClrColor = c;
        WrValid  = with_wr;
        WrX      = 10'd0;
        WrY      = 9'd0;
        WrData   = 1'b1;
        tick();
        ClrStart = 1'b0;
        WrValid  = 1'b0;
        busy_cyc = 0;
        while (Busy && busy_cyc < 20000) begin
            busy_cyc++;
            tick();
        end
    endtask

    initial begin
        int   cyc;
        int   low;
        logic pix, vld;

        // expected-value table
        add_vec(1, 0, 0, 1'b1);
        add_vec(1, 639, 479, 1'b1);
        add_vec(1, 320, 240, 1'b1);
        add_vec(1, 640, 0, 1'b0);
        add_vec(1, 0, 480, 1'b0);
        add_vec(2, 17, 3, 1'b1);
        add_vec(2, 16, 3, 1'b0);
        add_vec(2, 18, 3, 1'b0);
        add_vec(2, 17, 2, 1'b0);
        add_vec(3, 640, 0, 1'b0);
        add_vec(3, 0, 480, 1'b0);
        add_vec(3, 0, 1, 1'b0);
        add_vec(3, 639, 479, 1'b0);
        add_vec(4, 0, 0, 1'b0);
        add_vec(4, 17, 3, 1'b0);
        add_vec(4, 16, 5, 1'b0);
        add_vec(5, 0, 0, 1'b1);
        add_vec(5, 160, 1, 1'b1);
        add_vec(5, 304, 2, 1'b1);
        add_vec(5, 319, 2, 1'b1);
        add_vec(5, 320, 2, 1'b0);
        add_vec(5, 336, 2, 1'b0);
        add_vec(5, 639, 479, 1'b0);

        Rst = 1'b1; PixValid = 1'b0; PixX = '0; PixY = '0;
        WrValid = 1'b0; WrX = '0; WrY = '0; WrData = 1'b0;
        ClrStart = 1'b0; ClrColor = 1'b0;
        tick();
        tick();
        check("rst_pixel", 32'(Pixel), 32'd0);
        check("rst_pixvalid", 32'(PixelValid), 32'd0);
        check("rst_wrready", 32'(WrReady), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_wrerr", 32'(WrErr), 32'd0);
        Rst = 1'b0;
        check("wrready_first_cycle", 32'(WrReady), 32'd0);
        tick();
        check("wrready_after_reset", 32'(WrReady), 32'd1);

        // full clear to 1
        do_clear(1'b1, 1'b0, cyc);
        check("clr1_busy_cycles", 32'(cyc), 32'd19200);
        check("clr1_wrready", 32'(WrReady), 32'd1);
        run_phase(1);

        // clear to 0 then single pixel write
        do_clear(1'b0, 1'b0, cyc);
        check("clr0_busy_cycles", 32'(cyc), 32'd19200);
        host_write(17, 3, 1'b1, low);
        check("wr_ready_low_cycles", 32'(low), 32'd3);
        run_phase(2);

        // out-of-range writes
        check("wrerr_before_oor", 32'(WrErr), 32'd0);
        wait_ready("oor");
        WrValid = 1'b1; WrX = 10'd640; WrY = 9'd0; WrData = 1'b1;
        tick();
        WrValid = 1'b0;
        check("oor_x_ready", 32'(WrReady), 32'd1);
        check("oor_x_busy", 32'(Busy), 32'd0);
        check("oor_x_wrerr", 32'(WrErr), 32'd1);
        WrValid = 1'b1; WrX = 10'd0; WrY = 9'd480;
        tick();
        WrValid = 1'b0;
        check("oor_y_ready", 32'(WrReady), 32'd1);
        check("oor_y_wrerr", 32'(WrErr), 32'd1);
        run_phase(3);

        // streaming row 5 across the word boundary at x=15/16
        host_write(15, 5, 1'b1, low);
        host_write(16, 5, 1'b1, low);
        wait_ready("stream");
        for (int c = 0; c <= 640; c++) begin
            if (c < 640) begin
                PixValid = 1'b1;
                PixX     = 10'(c);
                PixY     = 9'd5;
            end else begin
                PixValid = 1'b0;
            end
            tick();
            if (c >= 2) begin
                check($sformatf("stream_vld_x%0d", c - 1), 32'(PixelValid), 32'd1);
                check($sformatf("stream_pix_x%0d", c - 1), 32'(Pixel),
                      32'((c - 1 == 15) || (c - 1 == 16)));
            end
        end
        PixValid = 1'b0;
        tick();

        // collision: display read in the WR cycle sees the old word
        wait_ready("collision");
        WrValid = 1'b1; WrX = 10'd17; WrY = 9'd3; WrData = 1'b0;
        tick();
        WrValid = 1'b0;
        tick();
        tick();
        PixValid = 1'b1; PixX = 10'd17; PixY = 9'd3;
        tick();
        check("coll_wrready_back", 32'(WrReady), 32'd1);
        tick();
        check("coll_first_pix", 32'(Pixel), 32'd1);
        check("coll_first_vld", 32'(PixelValid), 32'd1);
        PixValid = 1'b0;
        tick();
        check("coll_second_pix", 32'(Pixel), 32'd0);
        check("coll_second_vld", 32'(PixelValid), 32'd1);

        // clear beats a simultaneous write; WrErr stays set
        do_clear(1'b0, 1'b1, cyc);
        check("prio_busy_cycles", 32'(cyc), 32'd19200);
        check("wrerr_sticky", 32'(WrErr), 32'd1);
        run_phase(4);

        // reset 100 cycles into a clear to 1
        wait_ready("partial");
        ClrStart = 1'b1; ClrColor = 1'b1;
        tick();
        ClrStart = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        PixValid = 1'b1; PixX = 10'd0; PixY = 9'd0;
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        PixValid = 1'b0;
        check("part_busy", 32'(Busy), 32'd0);
        check("part_flush0", 32'(PixelValid), 32'd0);
        check("part_wrerr_cleared", 32'(WrErr), 32'd0);
        tick();
        check("part_flush1", 32'(PixelValid), 32'd0);
        check("part_wrready", 32'(WrReady), 32'd1);
        run_phase(5);

        read_px(1, 0, pix, vld);
        check("final_pix(1,0)", 32'(pix), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_fb_pixel_source.md
Name: vga_fb_pixel_source

Overview:
- 1-bit-per-pixel 640x480 monochrome framebuffer that produces the Pixel bit consumed by the downstream VGA drawer stage.
- The display side looks up the pixel at the coordinate presented by the timing logic and returns it after a fixed latency.
- The host side writes single pixels through a valid/ready handshake, using a read-modify-write sequence.
- A clear command fills the whole buffer with one colour.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines
- WORD_W, 16, bits per RAM word (power of 2)
- WORDS_PER_LINE, H_ACTIVE/WORD_W = 40, RAM words per line
- DEPTH, WORDS_PER_LINE*V_ACTIVE = 19200, RAM depth
- AW, 15, RAM address width

Ports:
- Clk  in  1  system clock; all logic is on the rising edge
- Rst  in  1  synchronous, active-high reset
- PixValid  in  1  display lookup request this cycle
- PixX  in  10  display column
- PixY  in  9  display row
- Pixel  out  1  looked-up pixel value
- PixelValid  out  1  Pixel is valid this cycle
- WrValid  in  1  host pixel-write request
- WrReady  out  1  block can accept a write or clear
- WrX  in  10  write column
- WrY  in  9  write row
- WrData  in  1  pixel value to write
- ClrStart  in  1  start a full-buffer clear; sampled only when WrReady=1
- ClrColor  in  1  fill value for the clear
- Busy  out  1  an RMW or clear is in progress
- WrErr  out  1  sticky flag: an out-of-range write was dropped; cleared only by Rst

Behaviour:
- Reset: Pixel=0, PixelValid=0, WrReady=0 for one cycle then 1, Busy=0, WrErr=0, FSM=IDLE. RAM contents are not reset.
- Display path, port A, read-only, fixed 2-cycle latency:
  - Cycle 0: PixValid with PixX/PixY.
  - Cycle 0 address: PixY*40 + PixX[9:4], computed as (PixY<<5)+(PixY<<3)+PixX[9:4].
  - Cycle 1: RAM output is registered and bit index PixX[3:0] is pipelined alongside.
  - Cycle 2: Pixel = word[bit], PixelValid=1.
  - Bit 0 of a word is the leftmost pixel.
  - Back-to-back requests give one result per cycle.
  - If PixX>=640 or PixY>=480: PixelValid still asserts at cycle 2 with Pixel=0, and the RAM is not accessed.
  - The display path is never stalled by host activity.
- Host path, port B. FSM states: IDLE, RD, MOD, WR, CLR.
  - IDLE, WrReady=1:
    - ClrStart has priority over WrValid when both are asserted.
    - ClrStart: latch ClrColor, set the clear counter to 0, go to CLR.
    - WrValid with in-range coordinates: latch address, bit and data, go to RD.
    - WrValid with out-of-range coordinates: accept the handshake, set WrErr=1, stay in IDLE.
  - RD: issue the port-B read, go to MOD.
  - MOD: registered read data is available; replace the selected bit; go to WR.
  - WR: write the modified word, go to IDLE.
  - A write therefore takes 4 cycles from acceptance to the next WrReady=1.
  - CLR: write {WORD_W{ClrColor}} to address cnt each cycle, cnt++.
  - CLR ends after address DEPTH-1 is written: 19200 cycles, then back to IDLE.
  - WrReady=0 and Busy=1 in every state except IDLE.
- Handshake: a transfer occurs when WrValid & WrReady on a rising edge. WrX, WrY and WrData are sampled only at that edge.
- Port collisions: the RAM is read-first. A display read of a word being written in the same cycle returns the old word; the new value appears from the next read onward.
- Reset mid-operation:
  - Rst during RD/MOD/WR/CLR returns the FSM to IDLE immediately.
  - A partial clear leaves the already-written words filled and the rest unchanged.
  - An interrupted RMW leaves its word unmodified if the reset arrives before the WR cycle.
  - The display pipeline is flushed, so PixelValid=0 for the two cycles after reset.
- Arithmetic: all address arithmetic is unsigned AW bits. The maximum address is 19199, so there is no overflow.

Decomposition:
- Package vga_fb_pkg holds:
  - H_ACTIVE, V_ACTIVE, WORD_W, WORDS_PER_LINE, DEPTH, AW
  - the host FSM state enum (IDLE, RD, MOD, WR, CLR)
  - an address-compute function (x,y) -> {addr, bit}
- One sub-module, fb_ram_dp: simple dual-port RAM, WORD_W x DEPTH, read-first, registered read outputs on both ports, write on port B only.

Test Plan:
- Reset, then clear with ClrColor=1: Busy stays high for exactly 19200 cycles, and reads of (0,0), (639,479) and (320,240) all return Pixel=1 at 2-cycle latency.
- After clearing to 0, write (17,3)=1: WrReady is low for 3 cycles. Reading (17,3) gives 1; neighbours (16,3), (18,3) and (17,2) give 0.
- Write (640,0) or (0,480): accepted in one cycle with WrErr=1 and no RAM change. Reading either coordinate returns Pixel=0 with PixelValid=1.
- Stream PixValid for x=0..639 on row 5, after writing (15,5)=1 and (16,5)=1: PixelValid is continuous and Pixel=1 exactly at x=15 and x=16, checking the word boundary.
- Collision: PixValid for (17,3) in the same cycle as the WR state for (17,3)=0 over a stored 1. That read returns 1; the read on the next cycle returns 0.
- Rst asserted 100 cycles into a clear to 1 of an all-0 buffer: Busy=0 and WrReady=1 after reset. Word addresses 0..99 read as 1; address 100 onward reads as 0.
